// File: rtl/instr_fetch_if.sv
// Fetch-stage bundle: instruction-memory req/ack bus plus the decode-side
// instruction slot and redirect inputs coming back from execute.
interface instr_fetch_if;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck;
    logic [31:0] imemRdata;
    logic [31:0] instr;
    logic [31:0] pcOut;
    logic        instrValid;
    logic        instrReady;
    logic        redirect;
    logic        redirectKind;
    logic [31:0] immOp;
    logic [31:0] jalrBase;
    logic        addrErr;

    modport master (
        output imemReq, imemAddr, instr, pcOut, instrValid, addrErr,
        input  imemAck, imemRdata, instrReady, redirect, redirectKind, immOp, jalrBase
    );

    modport slave (
        input  imemReq, imemAddr, instr, pcOut, instrValid, addrErr,
        output imemAck, imemRdata, instrReady, redirect, redirectKind, immOp, jalrBase
    );
endinterface

// File: rtl/instr_fetch.sv
// RV32I instruction fetch: PC ownership, req/ack instruction memory fetch,
// one-entry prefetch buffer and branch/JAL/JALR redirect handling.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    instr_fetch_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] pf_instr_q, pf_instr_d;
    logic [31:0] pf_pc_q, pf_pc_d;
    logic        pf_valid_q, pf_valid_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] tgt_addr_q, tgt_addr_d;
    logic        addr_err_q, addr_err_d;

    logic        consume_s;
    logic        redir_s;
    logic        ack_s;
    logic [31:0] raw_tgt_s;
    logic [31:0] tgt_s;
    logic [31:0] seq_addr_s;

    assign bus.imemReq    = (state_q != WAIT) & ~reset;
    assign bus.imemAddr   = req_addr_q;
    assign bus.instr      = instr_q;
    assign bus.pcOut      = pc_q;
    assign bus.instrValid = instr_valid_q;
    assign bus.addrErr    = addr_err_q;

    // Next-state, slot, prefetch buffer and address computation.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        pf_instr_d    = pf_instr_q;
        pf_pc_d       = pf_pc_q;
        pf_valid_d    = pf_valid_q;
        req_addr_d    = req_addr_q;
        tgt_addr_d    = tgt_addr_q;
        addr_err_d    = addr_err_q;

        consume_s  = instr_valid_q & bus.instrReady;
        redir_s    = consume_s & bus.redirect;
        ack_s      = bus.imemAck & (state_q != WAIT);
        seq_addr_s = req_addr_q + 32'd4;
        if (bus.redirectKind) begin
            raw_tgt_s = (bus.jalrBase + bus.immOp) & 32'hFFFF_FFFE;
        end else begin
            raw_tgt_s = pc_q + bus.immOp;
        end
        // Bit1 of the raw target flags a misaligned jump; the fetch itself is word-aligned.
        tgt_s = {raw_tgt_s[31:2], 2'b00};
        if (redir_s && raw_tgt_s[1]) begin
            addr_err_d = 1'b1;
        end else begin
            addr_err_d = addr_err_q;
        end

        case (state_q)
            FETCH: begin
                if (ack_s) begin
                    if (redir_s) begin
                        instr_valid_d = 1'b0;
                        req_addr_d    = tgt_s;
                    end else if (!instr_valid_q || consume_s) begin
                        instr_d       = bus.imemRdata;
                        pc_d          = req_addr_q;
                        instr_valid_d = 1'b1;
                        req_addr_d    = seq_addr_s;
                    end else begin
                        pf_instr_d = bus.imemRdata;
                        pf_pc_d    = req_addr_q;
                        pf_valid_d = 1'b1;
                        req_addr_d = seq_addr_s;
                        state_d    = WAIT;
                    end
                end else begin
                    if (redir_s) begin
                        // The outstanding request must finish before the target can be issued.
                        tgt_addr_d    = tgt_s;
                        instr_valid_d = 1'b0;
                        state_d       = DRAIN;
                    end else if (consume_s) begin
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_valid_d = instr_valid_q;
                    end
                end
            end
            WAIT: begin
                if (redir_s) begin
                    instr_valid_d = 1'b0;
                    pf_valid_d    = 1'b0;
                    req_addr_d    = tgt_s;
                    state_d       = FETCH;
                end else if (consume_s) begin
                    instr_d       = pf_instr_q;
                    pc_d          = pf_pc_q;
                    instr_valid_d = 1'b1;
                    pf_valid_d    = 1'b0;
                    state_d       = FETCH;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                if (ack_s) begin
                    req_addr_d = tgt_addr_q;
                    state_d    = FETCH;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d       = FETCH;
                instr_valid_d = 1'b0;
                pf_valid_d    = 1'b0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            instr_q       <= NOP;
            pc_q          <= RESET_PC;
            instr_valid_q <= 1'b0;
            pf_instr_q    <= NOP;
            pf_pc_q       <= RESET_PC;
            pf_valid_q    <= 1'b0;
            req_addr_q    <= RESET_PC;
            tgt_addr_q    <= RESET_PC;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            pf_instr_q    <= pf_instr_d;
            pf_pc_q       <= pf_pc_d;
            pf_valid_q    <= pf_valid_d;
            req_addr_q    <= req_addr_d;
            tgt_addr_q    <= tgt_addr_d;
            addr_err_q    <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory returns ~address after a programmable
// number of wait states; each task checks hand-computed outputs cycle by cycle.
module tb_instr_fetch;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    int   lat;
    int   wcnt;

    instr_fetch_if bus ();

    instr_fetch #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.imemAck   = bus.imemReq && (wcnt >= lat);
    assign bus.imemRdata = ~bus.imemAddr;

    // Memory wait-state counter for the outstanding request.
    always @(posedge clk or posedge reset) begin
        if (reset)
            wcnt <= 0;
        else if (bus.imemReq)
            wcnt <= bus.imemAck ? 0 : wcnt + 1;
        else
            wcnt <= 0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests += 6;
        if (bus.imemReq !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", bus.imemReq); end
        if (bus.imemAddr !== 32'h100) begin fails++; $display("FAIL rst_addr got %h exp 00000100", bus.imemAddr); end
        if (bus.instrValid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", bus.instrValid); end
        if (bus.instr !== 32'h13) begin fails++; $display("FAIL rst_instr got %h exp 00000013", bus.instr); end
        if (bus.pcOut !== 32'h100) begin fails++; $display("FAIL rst_pc got %h exp 00000100", bus.pcOut); end
        if (bus.addrErr !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", bus.addrErr); end
    endtask

    task automatic test_sequential();
        logic [31:0] p;
        bus.instrReady = 1'b1;
        reset = 1'b0;
        #1;
        tests += 2;
        if (bus.imemReq !== 1'b1) begin fails++; $display("FAIL seq_req0 got %b exp 1", bus.imemReq); end
        if (bus.imemAddr !== 32'h100) begin fails++; $display("FAIL seq_addr0 got %h exp 00000100", bus.imemAddr); end
        for (int k = 0; k < 4; k++) begin
            tick();
            p = 32'h100 + 32'(4 * k);
            tests += 4;
            if (bus.instrValid !== 1'b1) begin fails++; $display("FAIL seq_valid[%0d] got %b exp 1", k, bus.instrValid); end
            if (bus.pcOut !== p) begin fails++; $display("FAIL seq_pc[%0d] got %h exp %h", k, bus.pcOut, p); end
            if (bus.instr !== ~p) begin fails++; $display("FAIL seq_instr[%0d] got %h exp %h", k, bus.instr, ~p); end
            if (bus.imemAddr !== p + 32'd4) begin fails++; $display("FAIL seq_addr[%0d] got %h exp %h", k, bus.imemAddr, p + 32'd4); end
        end
    endtask

    task automatic test_stall();
        bus.instrReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            tests += 3;
            if (bus.imemReq !== 1'b0) begin fails++; $display("FAIL stall_req[%0d] got %b exp 0", k, bus.imemReq); end
            if (bus.pcOut !== 32'h10C) begin fails++; $display("FAIL stall_pc[%0d] got %h exp 0000010c", k, bus.pcOut); end
            if (bus.imemAddr !== 32'h114) begin fails++; $display("FAIL stall_addr[%0d] got %h exp 00000114", k, bus.imemAddr); end
        end
        bus.instrReady = 1'b1;
        tick();
        tests += 4;
        if (bus.pcOut !== 32'h110) begin fails++; $display("FAIL rel_pc got %h exp 00000110", bus.pcOut); end
        if (bus.instr !== ~32'h110) begin fails++; $display("FAIL rel_instr got %h exp %h", bus.instr, ~32'h110); end
        if (bus.imemReq !== 1'b1) begin fails++; $display("FAIL rel_req got %b exp 1", bus.imemReq); end
        if (bus.imemAddr !== 32'h114) begin fails++; $display("FAIL rel_addr got %h exp 00000114", bus.imemAddr); end
        tick();
        tests += 2;
        if (bus.pcOut !== 32'h114) begin fails++; $display("FAIL rel2_pc got %h exp 00000114", bus.pcOut); end
        if (bus.imemAddr !== 32'h118) begin fails++; $display("FAIL rel2_addr got %h exp 00000118", bus.imemAddr); end
    endtask

    task automatic test_branch();
        bus.redirect     = 1'b1;
        bus.redirectKind = 1'b0;
        bus.immOp        = 32'h0000_00EC;
        tick();
        bus.redirect = 1'b0;
        tests += 2;
        if (bus.instrValid !== 1'b0) begin fails++; $display("FAIL br1_valid got %b exp 0", bus.instrValid); end
        if (bus.imemAddr !== 32'h200) begin fails++; $display("FAIL br1_addr got %h exp 00000200", bus.imemAddr); end
        tick();
        tests += 2;
        if (bus.pcOut !== 32'h200) begin fails++; $display("FAIL br2_pc got %h exp 00000200", bus.pcOut); end
        if (bus.imemAddr !== 32'h204) begin fails++; $display("FAIL br2_addr got %h exp 00000204", bus.imemAddr); end
        bus.redirect = 1'b1;
        bus.immOp    = 32'hFFFF_FFF0;
        tick();
        bus.redirect = 1'b0;
        tests += 2;
        if (bus.instrValid !== 1'b0) begin fails++; $display("FAIL br3_valid got %b exp 0", bus.instrValid); end
        if (bus.imemAddr !== 32'h1F0) begin fails++; $display("FAIL br3_addr got %h exp 000001f0", bus.imemAddr); end
        tick();
        tests += 4;
        if (bus.instrValid !== 1'b1) begin fails++; $display("FAIL br4_valid got %b exp 1", bus.instrValid); end
        if (bus.pcOut !== 32'h1F0) begin fails++; $display("FAIL br4_pc got %h exp 000001f0", bus.pcOut); end
        if (bus.instr !== ~32'h1F0) begin fails++; $display("FAIL br4_instr got %h exp %h", bus.instr, ~32'h1F0); end
        if (bus.imemAddr !== 32'h1F4) begin fails++; $display("FAIL br4_addr got %h exp 000001f4", bus.imemAddr); end
    endtask

    task automatic test_drain();
        lat              = 3;
        bus.redirect     = 1'b1;
        bus.redirectKind = 1'b1;
        bus.jalrBase     = 32'h0000_1001;
        bus.immOp        = 32'h0000_0004;
        tick();
        bus.redirect = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests += 3;
            if (bus.imemReq !== 1'b1) begin fails++; $display("FAIL dr_req[%0d] got %b exp 1", k, bus.imemReq); end
            if (bus.imemAddr !== 32'h1F4) begin fails++; $display("FAIL dr_addr[%0d] got %h exp 000001f4", k, bus.imemAddr); end
            if (bus.instrValid !== 1'b0) begin fails++; $display("FAIL dr_valid[%0d] got %b exp 0", k, bus.instrValid); end
            tick();
        end
        tests += 2;
        if (bus.imemAddr !== 32'h1004) begin fails++; $display("FAIL dr_tgt got %h exp 00001004", bus.imemAddr); end
        if (bus.instrValid !== 1'b0) begin fails++; $display("FAIL dr_drop got %b exp 0", bus.instrValid); end
        lat = 0;
        tick();
        tests += 3;
        if (bus.pcOut !== 32'h1004) begin fails++; $display("FAIL dr_pc got %h exp 00001004", bus.pcOut); end
        if (bus.instr !== ~32'h1004) begin fails++; $display("FAIL dr_instr got %h exp %h", bus.instr, ~32'h1004); end
        if (bus.addrErr !== 1'b0) begin fails++; $display("FAIL dr_err got %b exp 0", bus.addrErr); end
    endtask

    task automatic test_misaligned();
        bus.redirect     = 1'b1;
        bus.redirectKind = 1'b0;
        bus.immOp        = 32'h0000_0006;
        tick();
        bus.redirect = 1'b0;
        tests += 2;
        if (bus.imemAddr !== 32'h1008) begin fails++; $display("FAIL mis_addr got %h exp 00001008", bus.imemAddr); end
        if (bus.addrErr !== 1'b1) begin fails++; $display("FAIL mis_err got %b exp 1", bus.addrErr); end
        for (int k = 0; k < 2; k++) begin
            tick();
            tests += 2;
            if (bus.pcOut !== 32'h1008 + 32'(4 * k)) begin fails++; $display("FAIL mis_pc[%0d] got %h exp %h", k, bus.pcOut, 32'h1008 + 32'(4 * k)); end
            if (bus.addrErr !== 1'b1) begin fails++; $display("FAIL mis_sticky[%0d] got %b exp 1", k, bus.addrErr); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        bus.redirect = 1'b1;
        bus.immOp    = 32'hFFFF_EFEC;
        tick();
        bus.redirect = 1'b0;
        tests += 1;
        if (bus.imemAddr !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_tgt got %h exp fffffff8", bus.imemAddr); end
        for (int k = 0; k < 3; k++) begin
            tick();
            tests += 3;
            if (bus.pcOut !== exp_pc[k]) begin fails++; $display("FAIL wrap_pc[%0d] got %h exp %h", k, bus.pcOut, exp_pc[k]); end
            if (bus.imemAddr !== exp_pc[k] + 32'd4) begin fails++; $display("FAIL wrap_addr[%0d] got %h exp %h", k, bus.imemAddr, exp_pc[k] + 32'd4); end
            if (bus.addrErr !== 1'b1) begin fails++; $display("FAIL wrap_err[%0d] got %b exp 1", k, bus.addrErr); end
        end
    endtask

    task automatic test_async_reset();
        lat            = 3;
        bus.instrReady = 1'b0;
        tick();
        tests += 2;
        if (bus.imemReq !== 1'b1) begin fails++; $display("FAIL ar_req_pre got %b exp 1", bus.imemReq); end
        if (bus.instrValid !== 1'b1) begin fails++; $display("FAIL ar_valid_pre got %b exp 1", bus.instrValid); end
        #2;
        reset = 1'b1;
        #1;
        tests += 5;
        if (bus.imemReq !== 1'b0) begin fails++; $display("FAIL ar_req got %b exp 0", bus.imemReq); end
        if (bus.instrValid !== 1'b0) begin fails++; $display("FAIL ar_valid got %b exp 0", bus.instrValid); end
        if (bus.imemAddr !== 32'h100) begin fails++; $display("FAIL ar_addr got %h exp 00000100", bus.imemAddr); end
        if (bus.pcOut !== 32'h100) begin fails++; $display("FAIL ar_pc got %h exp 00000100", bus.pcOut); end
        if (bus.addrErr !== 1'b0) begin fails++; $display("FAIL ar_err got %b exp 0", bus.addrErr); end
    endtask

    initial begin
        tests            = 0;
        fails            = 0;
        lat              = 0;
        reset            = 1'b1;
        bus.instrReady   = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirectKind = 1'b0;
        bus.immOp        = 32'h0;
        bus.jalrBase     = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_branch();
        test_drain();
        test_misaligned();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the RV32I core: owns the program counter, fetches 32-bit words from instruction memory over a req/ack handshake, and presents one instruction at a time (with its PC) to decode, where `instr[31:7]` feeds immDecode. Branch, JAL and JALR redirects come back from execute using the decoded `immOp`. A one-entry prefetch buffer keeps memory busy while decode stalls.

## Interface
- `RESET_PC`, 32'h0000_0000, address of the first fetch after reset
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `imemReq`  out  1  fetch request; held with `imemAddr` stable until acked
- `imemAddr`  out  32  word address of the outstanding request
- `imemAck`  in  1  memory completes request this cycle; only meaningful while `imemReq`=1
- `imemRdata`  in  32  fetched word, valid in the `imemAck` cycle
- `instr`  out  32  instruction presented to decode
- `pcOut`  out  32  address of `instr`
- `instrValid`  out  1  `instr`/`pcOut` hold a live instruction
- `instrReady`  in  1  decode/execute consumes the instruction this cycle
- `redirect`  in  1  the consumed instruction changes control flow; sampled only on a consume
- `redirectKind`  in  1  0: target = `pcOut`+`immOp` (branch/JAL); 1: target = (`jalrBase`+`immOp`) with bit0 cleared (JALR)
- `immOp`  in  32  sign-extended immediate of the consumed instruction
- `jalrBase`  in  32  rs1 value for JALR
- `addrErr`  out  1  sticky: a redirect target had bit1 set

## Operation
- Consume = `instrValid` & `instrReady` at a rising edge. Redirect-consume = consume & `redirect`.
- Registers: slot (`instr`, `pcOut`, `instrValid`), prefetch buffer (`pfInstr`, `pfPc`, `pfValid`), `reqAddr` (drives `imemAddr`), `tgtAddr`, state ∈ {FETCH, WAIT, DRAIN}.
- `imemReq` = 1 in FETCH and DRAIN, 0 in WAIT and while `reset`=1.
- Target arithmetic is modulo 2^32. Target bits[1:0] are always forced to 0. If the computed bit1 was 1, `addrErr`←1 until reset.
- Sequential `reqAddr`+4 wraps 0xFFFF_FFFC → 0x0000_0000.
- FETCH:
  - ack & redirect-consume: discard data; slot invalid; `reqAddr`←target; stay FETCH.
  - ack & (slot empty or consume): slot←(`imemRdata`, `reqAddr`), valid; `reqAddr`+=4; stay FETCH.
  - ack & slot full & no consume: pf←(`imemRdata`, `reqAddr`), `pfValid`←1; `reqAddr`+=4; → WAIT.
  - no ack & redirect-consume: request must complete; `tgtAddr`←target; slot invalid; → DRAIN.
  - no ack & plain consume: slot invalid; stay FETCH.
- WAIT:
  - plain consume: slot←pf; `pfValid`←0; → FETCH.
  - redirect-consume: slot and pf invalid; `reqAddr`←target; → FETCH.
- DRAIN: slot is empty, so no consume is possible. On ack: discard data; `reqAddr`←`tgtAddr`; → FETCH.
- Reset mid-transaction abandons it. Memory must tolerate `imemReq` dropping without ack under reset.

## Timing
- Reset values: state FETCH, `reqAddr`=`imemAddr`=`RESET_PC`, `instr`=32'h0000_0013 (NOP), `pcOut`=`RESET_PC`, `instrValid`=0, `pfValid`=0, `addrErr`=0, `imemReq`=0.
- `imemReq` rises in the first cycle after `reset` deasserts.
- Zero-wait memory (ack in the request cycle): `instrValid` rises 1 cycle after the ack edge. Throughput is 1 instruction per cycle with `instrReady` held at 1.
- Redirect penalty with zero-wait memory: target instruction valid 2 edges after the redirect-consume. Add one cycle per DRAIN wait state.
- `imemAddr` changes only at the edge of an ack, a FETCH/WAIT redirect, or reset. It never changes while a request is un-acked.
- All outputs are registered except `imemReq` (decoded from state and `reset`).

## Test plan
- Reset release, RESET_PC=0x100, ack every cycle, `instrReady`=1 → `imemAddr` 0x100, 0x104, 0x108…; `instrValid` from cycle 2; `pcOut` tracks 1 cycle behind.
- Stall: `instrReady`=0 for 5 cycles with slot holding 0x104 → exactly one more fetch (0x108) into pf, `imemReq`=0 in WAIT. Release → 0x108 presented next cycle, then 0x10C fetched.
- Branch: consume at `pcOut`=0x200, `redirect`=1, kind 0, `immOp`=0xFFFF_FFF0 → next `imemAddr`=0x1F0, next `pcOut`=0x1F0, no instruction from 0x204 ever valid.
- Redirect during 3-cycle memory latency: JALR, `jalrBase`=0x1001, `immOp`=4 → old request held until ack, its data dropped, then `imemAddr`=0x1004.
- Misaligned: kind 0, `pcOut`=0x10, `immOp`=6 → `imemAddr`=0x14, `addrErr`=1 and stays 1.
- Wrap and async reset: sequential fetch past 0xFFFF_FFFC → 0x0. Assert `reset` mid-request → `imemReq`=0 and `instrValid`=0 immediately, without a clock edge.
